// File: rtl/wbu_commit_if.sv
// Execute-to-commit and commit-to-fetch handshake bundle for wbu_commit.
// The slave modport is the commit stage; the master modport is its surroundings.
interface wbu_commit_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    // Execute stage -> commit
    logic            EXU_valid;
    logic            WBU_ready;
    logic [XLEN-1:0] wd;
    logic [AW-1:0]   rd;
    logic            regwr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] src1;
    logic            PCAsrc;
    logic            PCBsrc;

    // Commit -> fetch stage
    logic            WBU_valid;
    logic            IFU_ready;
    logic [XLEN-1:0] next_pc;

    modport master (
        output EXU_valid, wd, rd, regwr, pc, imm, src1, PCAsrc, PCBsrc, IFU_ready,
        input  WBU_ready, WBU_valid, next_pc
    );

    modport slave (
        input  EXU_valid, wd, rd, regwr, pc, imm, src1, PCAsrc, PCBsrc, IFU_ready,
        output WBU_ready, WBU_valid, next_pc
    );
endinterface

// File: rtl/wbu_commit.sv
// Write-back/commit stage: owns the architectural register file, retires one
// instruction per handshake, and hands the computed next PC to fetch.
module wbu_commit #(
    parameter int              NREG     = 32,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    wbu_commit_if.slave             bus,
    input  logic [$clog2(NREG)-1:0] rs1_addr,
    input  logic [$clog2(NREG)-1:0] rs2_addr,
    output logic [XLEN-1:0]         rs1_data,
    output logic [XLEN-1:0]         rs2_data,
    output logic [31:0]             commit_cnt
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        IDLE = 2'd1,
        HAND = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] next_pc_q, next_pc_d;
    logic [31:0]     commit_cnt_q, commit_cnt_d;
    logic [XLEN-1:0] regs_q [NREG];

    logic            accept;
    logic            retire;
    logic [XLEN-1:0] pc_base;
    logic [XLEN-1:0] pc_offset;
    logic [XLEN-1:0] pc_sum;

    assign accept = bus.EXU_valid & bus.WBU_ready;
    // Only the HAND-state hand-off retires an instruction; the boot PC does not count.
    assign retire = bus.WBU_valid & bus.IFU_ready & (state_q == HAND);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    if (bus.IFU_ready) state_d = IDLE;
            IDLE:    if (bus.EXU_valid) state_d = HAND;
            HAND:    if (bus.IFU_ready) state_d = IDLE;
            default: state_d = BOOT;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        bus.WBU_ready = 1'b0;
        bus.WBU_valid = 1'b0;
        unique case (state_q)
            BOOT:    bus.WBU_valid = 1'b1;
            IDLE:    bus.WBU_ready = 1'b1;
            HAND:    bus.WBU_valid = 1'b1;
            default: bus.WBU_valid = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-PC computation; jalr targets drop bit 0.
    // ------------------------------------------------------------------
    assign pc_base   = bus.PCBsrc ? bus.src1 : bus.pc;
    assign pc_offset = bus.PCAsrc ? bus.imm : XLEN'(4);
    assign pc_sum    = pc_base + pc_offset;

    always_comb begin
        next_pc_d    = next_pc_q;
        commit_cnt_d = commit_cnt_q;
        if (accept) begin
            next_pc_d = pc_sum & ~{{(XLEN-1){1'b0}}, bus.PCBsrc};
        end
        if (retire) begin
            commit_cnt_d = commit_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            next_pc_q    <= RESET_PC;
            commit_cnt_q <= '0;
        end else begin
            next_pc_q    <= next_pc_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Architectural register file; x0 is never written.
    // ------------------------------------------------------------------
    // NOTE: the array is flop-based and explicitly reset because software
    // relies on every architectural register reading 0 after reset; a RAM
    // macro could not offer that.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (accept && bus.regwr && (bus.rd != '0)) begin
            regs_q[bus.rd] <= bus.wd;
        end
    end

    // No bypass: decode cannot issue until fetch consumes next_pc, by which
    // time the write has already landed.
    assign rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];

    assign bus.next_pc = next_pc_q;
    assign commit_cnt  = commit_cnt_q;

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    property p_pc_stable_under_stall;
        @(posedge clk) disable iff (!rst)
            (state_q == HAND && !bus.IFU_ready) |=> (next_pc_q == $past(next_pc_q));
    endproperty
    a_pc_stable_under_stall: assert property (p_pc_stable_under_stall);

    property p_handshakes_exclusive;
        @(posedge clk) disable iff (!rst)
            !(bus.WBU_ready && bus.WBU_valid);
    endproperty
    a_handshakes_exclusive: assert property (p_handshakes_exclusive);

endmodule

// File: tb/tb_wbu_commit.sv
// Scoreboard bench for wbu_commit: stimulus pushes expected fetch hand-offs,
// a negedge monitor pops and compares them when the fetch handshake fires.
module tb_wbu_commit;

    localparam int          XLEN     = 32;
    localparam int          NREG     = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data, commit_cnt;

    always #5 clk = ~clk;

    wbu_commit_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

    wbu_commit #(.NREG(NREG), .XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .commit_cnt (commit_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_cnt  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction from IDLE and leave the DUT in HAND.
    task automatic issue(input logic [4:0] rd, input logic [31:0] wd, input logic regwr,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] src1,
                         input logic pca, input logic pcb, input logic [31:0] exp_pc);
        check("idle_ready", {31'd0, bus.WBU_ready}, 32'd1);
        bus.EXU_valid = 1'b1;
        bus.rd        = rd;
        bus.wd        = wd;
        bus.regwr     = regwr;
        bus.pc        = pc;
        bus.imm       = imm;
        bus.src1      = src1;
        bus.PCAsrc    = pca;
        bus.PCBsrc    = pcb;
        exp_q.push_back('{pc: exp_pc, cnt: exp_cnt});
        step();
        bus.EXU_valid = 1'b0;
        check("hand_ready", {31'd0, bus.WBU_ready}, 32'd0);
        check("hand_valid", {31'd0, bus.WBU_valid}, 32'd1);
    endtask

    // Stall fetch for a number of cycles, then accept next_pc for one cycle.
    task automatic handoff(input int stalls, input bit counts);
        bus.IFU_ready = 1'b0;
        repeat (stalls) step();
        bus.IFU_ready = 1'b1;
        step();
        bus.IFU_ready = 1'b0;
        if (counts) exp_cnt++;
        check("post_valid", {31'd0, bus.WBU_valid}, 32'd0);
        check("post_ready", {31'd0, bus.WBU_ready}, 32'd1);
        check("post_cnt", commit_cnt, exp_cnt);
    endtask

    // Monitor: the fetch handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst && bus.WBU_valid && bus.IFU_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_handoff", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("next_pc", bus.next_pc, e.pc);
                check("handoff_cnt", commit_cnt, e.cnt);
            end
        end
    end

    initial begin
        bus.EXU_valid = 1'b0;
        bus.IFU_ready = 1'b0;
        bus.rd        = '0;
        bus.wd        = '0;
        bus.regwr     = 1'b0;
        bus.pc        = '0;
        bus.imm       = '0;
        bus.src1      = '0;
        bus.PCAsrc    = 1'b0;
        bus.PCBsrc    = 1'b0;
        rs1_addr      = 5'd5;
        rs2_addr      = 5'd0;

        // Reset state
        #2 rst = 1'b0;
        #10;
        check("rst_valid", {31'd0, bus.WBU_valid}, 32'd1);
        check("rst_ready", {31'd0, bus.WBU_ready}, 32'd0);
        check("rst_pc", bus.next_pc, RESET_PC);
        check("rst_cnt", commit_cnt, 32'd0);
        check("rst_reg5", rs1_data, 32'd0);

        // Boot hand-off of RESET_PC, not counted
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.push_back('{pc: RESET_PC, cnt: 32'd0});
        handoff(0, 1'b0);

        // Plain add into x5
        rs1_addr = 5'd5;
        issue(5'd5, 32'h0000_1234, 1'b1, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8000_0004);
        check("add_x5", rs1_data, 32'h0000_1234);
        handoff(0, 1'b1);

        // jalr: bit 0 of the target cleared
        rs2_addr = 5'd1;
        issue(5'd1, 32'h8000_0008, 1'b1, 32'h8000_0004, 32'h0000_0010, 32'h8000_0101,
              1'b1, 1'b1, 32'h8000_0110);
        check("jalr_x1", rs2_data, 32'h8000_0008);
        handoff(2, 1'b1);

        // Write to x0 discarded; backwards branch
        rs1_addr = 5'd0;
        rs2_addr = 5'd5;
        issue(5'd0, 32'hDEAD_BEEF, 1'b1, 32'h8000_0010, 32'hFFFF_FFF8, 32'h0,
              1'b1, 1'b0, 32'h8000_0008);
        check("x0_zero", rs1_data, 32'h0);
        check("x5_kept", rs2_data, 32'h0000_1234);
        handoff(0, 1'b1);

        // Backpressure with a new instruction waiting upstream
        rs1_addr = 5'd7;
        issue(5'd7, 32'h0000_0077, 1'b1, 32'h0000_0100, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_0104);
        bus.EXU_valid = 1'b1;
        bus.rd        = 5'd5;
        bus.wd        = 32'h0000_AAAA;
        bus.regwr     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_pc", bus.next_pc, 32'h0000_0104);
            check("bp_ready", {31'd0, bus.WBU_ready}, 32'd0);
            check("bp_x5", rs2_data, 32'h0000_1234);
            check("bp_cnt", commit_cnt, 32'd3);
        end
        check("bp_x7", rs1_data, 32'h0000_0077);
        bus.EXU_valid = 1'b0;
        handoff(0, 1'b1);
        check("bp_x5_after", rs2_data, 32'h0000_1234);

        // Reset asserted mid-HAND
        rs1_addr = 5'd9;
        issue(5'd9, 32'h0000_0099, 1'b1, 32'h0000_0200, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_0204);
        check("x9_written", rs1_data, 32'h0000_0099);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, bus.WBU_valid}, 32'd1);
        check("mid_rst_ready", {31'd0, bus.WBU_ready}, 32'd0);
        check("mid_rst_pc", bus.next_pc, RESET_PC);
        check("mid_rst_cnt", commit_cnt, 32'd0);
        check("mid_rst_x9", rs1_data, 32'd0);
        check("mid_rst_x5", rs2_data, 32'd0);
        exp_q.delete();
        exp_cnt = '0;

        // Recovery: boot again, then one more instruction
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.push_back('{pc: RESET_PC, cnt: 32'd0});
        handoff(0, 1'b0);
        rs1_addr = 5'd3;
        issue(5'd3, 32'h0000_0033, 1'b1, RESET_PC, 32'h0000_0020, 32'h0, 1'b1, 1'b0, 32'h8000_0020);
        check("recover_x3", rs1_data, 32'h0000_0033);
        handoff(1, 1'b1);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wbu_commit.md
Name: wbu_commit

Overview:
- Write-back/commit stage directly downstream of the execute stage.
- Accepts one retired instruction per valid/ready handshake and writes the result into the architectural register file it owns.
- Computes the next PC from the branch-select outputs of the execute stage and hands that PC to the fetch stage over a second valid/ready handshake.
- Serves the decode stage with two combinational register read ports and keeps a retired-instruction counter.

Parameters:
- NREG, 32, number of architectural registers; x0 is hardwired zero.
- XLEN, 32, data and PC width.
- RESET_PC, 32'h8000_0000, first PC issued to fetch after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- EXU_valid  in  1  execute stage holds a finished instruction.
- WBU_ready  out  1  this stage can accept an instruction.
- wd  in  XLEN  write-back data (ALU result or load data).
- rd  in  $clog2(NREG)  destination register index.
- regwr  in  1  instruction writes rd.
- pc  in  XLEN  PC of the instruction.
- imm  in  XLEN  immediate.
- src1  in  XLEN  rs1 value, used as the jalr base.
- PCAsrc  in  1  1: offset = imm; 0: offset = 4.
- PCBsrc  in  1  1: base = src1; 0: base = pc.
- WBU_valid  out  1  next_pc is valid for fetch.
- IFU_ready  in  1  fetch accepts next_pc.
- next_pc  out  XLEN  PC for fetch.
- rs1_addr  in  $clog2(NREG)  read port 1 index.
- rs2_addr  in  $clog2(NREG)  read port 2 index.
- rs1_data  out  XLEN  combinational read; 0 when index is 0.
- rs2_data  out  XLEN  combinational read; 0 when index is 0.
- commit_cnt  out  32  retired-instruction count.

Behaviour:
- States:
  - BOOT: issue RESET_PC.
  - IDLE: WBU_ready=1, WBU_valid=0.
  - HAND: WBU_ready=0, WBU_valid=1.
- Reset (rst=0, asynchronous):
  - state=BOOT, WBU_ready=0, WBU_valid=1, next_pc=RESET_PC, commit_cnt=0.
  - All registers cleared to 0.
- Release of reset is sampled synchronously. No handshake completes on the edge where rst is low.
- BOOT:
  - When IFU_ready=1: go to IDLE, WBU_valid<=0, WBU_ready<=1.
  - commit_cnt is not incremented.
- IDLE, accept = EXU_valid & WBU_ready. On the accepting edge:
  - If regwr=1 and rd!=0: reg[rd]<=wd. A write to x0 is discarded.
  - next_pc <= (PCBsrc ? src1 : pc) + (PCAsrc ? imm : 4), modulo 2^XLEN. Bit 0 is forced to 0 when PCBsrc=1 (jalr).
  - state<=HAND, WBU_ready<=0, WBU_valid<=1.
- Accept latency: the register is visible on rs*_data and next_pc is valid the cycle after the accepting edge.
- IDLE with EXU_valid=0: hold all state.
- HAND:
  - next_pc is held stable while WBU_valid=1 and IFU_ready=0.
  - On IFU_ready=1: commit_cnt<=commit_cnt+1 (wraps 0xFFFF_FFFF→0), WBU_valid<=0, WBU_ready<=1, state<=IDLE.
  - Total minimum occupancy is 2 cycles per instruction.
- No new acceptance occurs in BOOT or HAND, because WBU_ready=0. EXU_valid asserted there is ignored, and its inputs must stay stable per the handshake.
- Read ports:
  - Purely combinational from the register array; no bypass of an in-flight write.
  - The write lands at the accepting edge, and decode cannot issue until fetch has consumed next_pc, so no hazard exists.
- Reset mid-operation: any state aborts immediately to BOOT values; a pending write that has not reached its edge is lost.

Test Plan:
- Reset then release with IFU_ready=1 -> next_pc=0x8000_0000, WBU_valid high for exactly 1 cycle, commit_cnt=0, WBU_ready=1 next cycle.
- Accept add: rd=5, wd=0x1234, regwr=1, pc=0x8000_0000, PCAsrc=PCBsrc=0 -> rs1_addr=5 reads 0x1234 next cycle; next_pc=0x8000_0004; commit_cnt=1 after IFU_ready.
- jalr: PCAsrc=1, PCBsrc=1, src1=0x8000_0101, imm=0x10, rd=1, wd=0x8000_0008 -> next_pc=0x8000_0110 (bit0 cleared); reg[1]=0x8000_0008.
- Write to x0 with wd=0xDEAD_BEEF, plus branch PCAsrc=1, imm=0xFFFF_FFF8, pc=0x8000_0010 -> rs1 read of x0 =0; next_pc=0x8000_0008.
- Backpressure: IFU_ready held 0 for 5 cycles in HAND while EXU_valid=1 with new data -> next_pc stable, WBU_ready=0, no register change, commit_cnt unchanged until IFU_ready.
- Assert rst low mid-HAND -> outputs immediately at reset values (WBU_valid=1, next_pc=RESET_PC), all registers read 0, commit_cnt=0.
